// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter byte interface among NREQ byte sources.
//   A round-robin arbiter picks a requester. With PACKET_LOCK it keeps that
//   requester granted until the last byte of its packet. Each byte is then
//   sequenced through the UART: a one-cycle write strobe, a wait for BUSY to
//   rise (bounded by TIMEOUT), and a wait for BUSY to fall. Only one byte is
//   outstanding at a time, and there is no buffering.
//
// Parameters
//   NREQ        number of requesters (2..8)
//   N           byte width, equal to the UART data width
//   PACKET_LOCK 1: hold the grant until a byte with REQ_LAST=1 is taken
//               0: re-arbitrate after every byte
//   TIMEOUT     cycles allowed for UART_BUSY to rise after the strobe (>=2)
//
// Ports
//   CLOCK, RESET_N  rising-edge clock; asynchronous active-low reset
//   REQ_VALID[i]    requester i presents a byte
//   REQ_DATA        requester i drives bits [i*N +: N]
//   REQ_LAST[i]     the byte presented by requester i ends its packet
//   REQ_READY[i]    one-hot, combinational accept; the byte is taken when
//                   REQ_VALID[i] & REQ_READY[i]
//   UART_DATAI      accepted byte; held until the next acceptance
//   UART_WR         one-cycle write strobe, the cycle after acceptance
//   UART_BUSY       UART transmitter busy (may also come from another sender)
//   GRANT_ID        index of the last accepted requester
//   ACTIVE          a byte is in flight (the arbiter is not idle)
//   ERR_TIMEOUT     sticky: UART_BUSY did not rise within TIMEOUT cycles
//   CLR_ERR         synchronous clear of ERR_TIMEOUT; a new timeout wins
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned N           = 8,
  parameter int unsigned PACKET_LOCK = 1,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                      CLOCK,
  input  logic                      RESET_N,
  input  logic [NREQ-1:0]           REQ_VALID,
  input  logic [NREQ*N-1:0]         REQ_DATA,
  input  logic [NREQ-1:0]           REQ_LAST,
  output logic [NREQ-1:0]           REQ_READY,
  output logic [N-1:0]              UART_DATAI,
  output logic                      UART_WR,
  input  logic                      UART_BUSY,
  output logic [$clog2(NREQ)-1:0]   GRANT_ID,
  output logic                      ACTIVE,
  output logic                      ERR_TIMEOUT,
  input  logic                      CLR_ERR
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] PTR_RESET = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_grant;
  logic            r_lock;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_data;
  logic            r_err;

  logic            w_found;
  logic [IDW-1:0]  w_sel;
  logic            w_accept;
  logic [N-1:0]    w_sel_data;
  logic            w_sel_last;
  logic            w_lock_nxt;
  logic            w_timeout;

  // Requester selection: the locked owner only, else the first valid
  // requester after the round-robin pointer.
  always_comb begin : p_select
    logic [IDW-1:0] cand;
    cand    = '0;
    w_found = 1'b0;
    w_sel   = '0;
    if (r_lock) begin
      w_found = REQ_VALID[r_grant];
      w_sel   = r_grant;
    end else begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        cand = IDW'((32'(r_ptr) + k) % NREQ);
        if (!w_found && REQ_VALID[cand]) begin
          w_found = 1'b1;
          w_sel   = cand;
        end
      end
    end
  end

  // A byte is taken only while idle and while nobody else drives the UART.
  assign w_accept   = (r_state == ST_ARB) && w_found && !UART_BUSY;
  assign w_sel_data = REQ_DATA[32'(w_sel) * N +: N];
  assign w_sel_last = REQ_LAST[w_sel];
  assign w_lock_nxt = (PACKET_LOCK != 0) && !w_sel_last;
  assign w_timeout  = (r_state == ST_WAIT_BUSY) && !UART_BUSY && (r_cnt == CNT_LAST);

  // Ready is combinational so the source sees it in the accepting cycle;
  // it is forced low while reset is asserted.
  assign REQ_READY = (w_accept && RESET_N) ? (NREQ'(1) << w_sel) : '0;

  // State register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB: begin
        if (w_accept) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (UART_BUSY)      w_state_nxt = ST_WAIT_DONE;
        else if (w_timeout) w_state_nxt = ST_ARB;
      end
      ST_WAIT_DONE: begin
        if (!UART_BUSY) w_state_nxt = ST_ARB;
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  // Datapath: captured byte, grant, lock, pointer, timeout counter, error.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_data  <= '0;
      r_grant <= '0;
      r_lock  <= 1'b0;
      r_ptr   <= PTR_RESET;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= w_sel_data;
        r_grant <= w_sel;
        r_lock  <= w_lock_nxt;
        // The pointer only moves once the grant is released.
        if (!w_lock_nxt) r_ptr <= w_sel;
      end

      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if ((r_state == ST_WAIT_BUSY) && !UART_BUSY && !w_timeout) begin
        r_cnt <= r_cnt + CW'(1);
      end

      // A lost byte releases the grant; its owner goes to the back of the line.
      if (w_timeout) begin
        r_lock <= 1'b0;
        r_ptr  <= r_grant;
      end

      if (w_timeout)    r_err <= 1'b1;
      else if (CLR_ERR) r_err <= 1'b0;
    end
  end

  assign UART_WR     = (r_state == ST_ISSUE);
  assign ACTIVE      = (r_state != ST_ARB);
  assign UART_DATAI  = r_data;
  assign GRANT_ID    = r_grant;
  assign ERR_TIMEOUT = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed scenarios followed by a randomized run. Every cycle the outputs
//   are compared against a transaction-level model that tracks the time since
//   the last accepted byte, the round-robin pointer and the packet lock.
//   The bench also acts as the UART, answering each write strobe with a BUSY
//   pulse (or with no answer, to force a timeout).
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 8;
  localparam int PL   = 1;
  localparam int TMO  = 16;
  localparam int QD   = 64;

  logic                 CLOCK;
  logic                 RESET_N;
  logic [NREQ-1:0]      REQ_VALID;
  logic [NREQ*N-1:0]    REQ_DATA;
  logic [NREQ-1:0]      REQ_LAST;
  logic [NREQ-1:0]      REQ_READY;
  logic [N-1:0]         UART_DATAI;
  logic                 UART_WR;
  logic                 UART_BUSY;
  logic [1:0]           GRANT_ID;
  logic                 ACTIVE;
  logic                 ERR_TIMEOUT;
  logic                 CLR_ERR;

  uart_tx_arbiter #(
    .NREQ(NREQ), .N(N), .PACKET_LOCK(PL), .TIMEOUT(TMO)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST),
    .REQ_READY(REQ_READY), .UART_DATAI(UART_DATAI), .UART_WR(UART_WR),
    .UART_BUSY(UART_BUSY), .GRANT_ID(GRANT_ID), .ACTIVE(ACTIVE),
    .ERR_TIMEOUT(ERR_TIMEOUT), .CLR_ERR(CLR_ERR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Per-requester byte queues: {last, data}.
  logic [N:0] qb [NREQ][QD];
  int qh [NREQ];
  int qt [NREQ];

  // Stimulus knobs (percentages unless noted).
  int k_stall, k_refill, k_noresp, k_ext, k_clr, k_dly, k_lmin, k_lmax;
  bit k_clr_infl;

  // UART behaviour: idle cycles before BUSY rises, then remaining BUSY cycles.
  int u_wait = -1;
  int u_len  = 0;

  // Reference model.
  int         m_ptr, m_grant, m_age;
  bit         m_lock, m_err, m_infl, m_saw;
  logic [N-1:0] m_data;

  int acc_log[$];
  int obs_rdy, obs_wr, wr_cyc, err_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int qn(input int i);
    return qt[i] - qh[i];
  endfunction

  task automatic push(input int i, input logic [N-1:0] d, input bit last);
    if (qt[i] < QD) begin
      qb[i][qt[i]] = {last, d};
      qt[i]++;
    end
  endtask

  task automatic model_reset();
    m_ptr  = NREQ - 1;
    m_grant = 0;
    m_age  = 0;
    m_lock = 1'b0;
    m_err  = 1'b0;
    m_infl = 1'b0;
    m_saw  = 1'b0;
    m_data = '0;
  endtask

  // Drive this cycle's inputs.
  task automatic gen_inputs();
    logic [N:0] w;
    bit b;
    int len;
    for (int i = 0; i < NREQ; i++) begin
      if (k_refill > 0 && qn(i) == 0 && $urandom_range(0, 99) < k_refill) begin
        qh[i] = 0;
        qt[i] = 0;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) push(i, N'($urandom), j == len - 1);
      end
      w = (qn(i) > 0) ? qb[i][qh[i]] : (N+1)'($urandom);
      REQ_VALID[i]          = (qn(i) > 0) && ($urandom_range(0, 99) >= k_stall);
      REQ_DATA[i*N +: N]    = w[N-1:0];
      REQ_LAST[i]           = w[N];
    end
    if (u_len > 0) begin
      b = 1'b1;
      u_len--;
    end else if (u_wait == 0) begin
      b = 1'b1;
      u_len  = $urandom_range(k_lmin, k_lmax) - 1;
      u_wait = -1;
    end else begin
      if (u_wait > 0) u_wait--;
      b = !m_infl && (u_wait < 0) && ($urandom_range(0, 99) < k_ext);
      if (b) u_len = $urandom_range(0, 3);
    end
    UART_BUSY = b;
    CLR_ERR   = k_clr_infl ? m_infl : ($urandom_range(0, 99) < k_clr);
  endtask

  // Compare against the model, then advance the model past the next edge.
  task automatic eval_cycle();
    int sel;
    logic [NREQ-1:0] er;
    logic [N:0] w;
    bit tmo;
    sel = -1;
    er  = '0;
    if (!m_infl) begin
      if (m_lock) begin
        if (REQ_VALID[m_grant]) sel = m_grant;
      end else begin
        for (int k = 1; k <= NREQ; k++)
          if (sel < 0 && REQ_VALID[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
      end
      if (UART_BUSY) sel = -1;
      if (sel >= 0) er[sel] = 1'b1;
    end
    chk("ready",  REQ_READY, er);
    chk("wr",     UART_WR, m_infl && m_age == 1);
    chk("active", ACTIVE, m_infl);
    chk("grant",  GRANT_ID, m_grant);
    chk("err",    ERR_TIMEOUT, m_err);
    chk("data",   UART_DATAI, m_data);

    if (REQ_READY != '0) obs_rdy++;
    if (UART_WR === 1'b1) begin
      obs_wr++;
      wr_cyc = cyc;
      if ($urandom_range(0, 99) >= k_noresp) u_wait = $urandom_range(0, k_dly);
    end
    if (ERR_TIMEOUT === 1'b1 && err_cyc < 0) err_cyc = cyc;

    tmo = 1'b0;
    if (sel >= 0) begin
      w = qb[sel][qh[sel]];
      qh[sel]++;
      m_data  = w[N-1:0];
      m_grant = sel;
      m_lock  = (PL != 0) && !w[N];
      if (!m_lock) m_ptr = sel;
      m_infl = 1'b1;
      m_age  = 1;
      m_saw  = 1'b0;
      acc_log.push_back(sel);
    end else if (m_infl) begin
      if (m_saw) begin
        if (!UART_BUSY) m_infl = 1'b0;
      end else if (m_age >= 2) begin
        if (UART_BUSY) m_saw = 1'b1;
        else if (m_age - 1 == TMO) begin
          tmo    = 1'b1;
          m_lock = 1'b0;
          m_ptr  = m_grant;
          m_infl = 1'b0;
        end
      end
      m_age++;
    end
    if (tmo)          m_err = 1'b1;
    else if (CLR_ERR) m_err = 1'b0;
    cyc++;
  endtask

  task automatic tick();
    @(negedge CLOCK);
    gen_inputs();
    #1;
    eval_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int n, input int budget);
    int b = 0;
    while (acc_log.size() < n && b < budget) begin
      tick();
      b++;
    end
    chk("wait_bound", acc_log.size() >= n, 1);
  endtask

  // Asynchronous reset between clock edges; outputs must drop at once.
  task automatic do_reset(input string tag);
    #2;
    RESET_N   = 1'b0;
    UART_BUSY = 1'b0;
    CLR_ERR   = 1'b0;
    #1;
    chk({tag, "_ready"},  REQ_READY, 0);
    chk({tag, "_wr"},     UART_WR, 0);
    chk({tag, "_data"},   UART_DATAI, 0);
    chk({tag, "_grant"},  GRANT_ID, 0);
    chk({tag, "_active"}, ACTIVE, 0);
    chk({tag, "_err"},    ERR_TIMEOUT, 0);
    REQ_VALID = '0;
    model_reset();
    for (int i = 0; i < NREQ; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    u_wait = -1;
    u_len  = 0;
    acc_log.delete();
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t2_exp[6];
    int t3_exp[5];
    t2_exp = '{0, 1, 2, 3, 0, 1};
    t3_exp = '{2, 2, 2, 3, 0};
    RESET_N = 1'b0;
    REQ_VALID = '0;
    REQ_DATA  = '0;
    REQ_LAST  = '0;
    UART_BUSY = 1'b0;
    CLR_ERR   = 1'b0;
    k_stall = 0; k_refill = 0; k_noresp = 0; k_ext = 0; k_clr = 0;
    k_dly = 0; k_lmin = 20; k_lmax = 20; k_clr_infl = 1'b0;
    wr_cyc = -1; err_cyc = -1;
    model_reset();
    do_reset("rst");

    // Single byte; UART busy from one cycle after the strobe for 20 cycles.
    push(0, 8'h5A, 1'b1);
    obs_rdy = 0; obs_wr = 0;
    run(30);
    chk("t1_ready_pulses", obs_rdy, 1);
    chk("t1_wr_pulses", obs_wr, 1);
    chk("t1_data", UART_DATAI, 8'h5A);
    chk("t1_grant", GRANT_ID, 0);
    chk("t1_active", ACTIVE, 0);

    // Round-robin with all requesters valid, single-byte packets.
    do_reset("rst2");
    k_lmin = 2; k_lmax = 2;
    for (int i = 0; i < NREQ; i++) begin
      push(i, N'($urandom), 1'b1);
      push(i, N'($urandom), 1'b1);
    end
    run_until(6, 200);
    for (int k = 0; k < 6; k++) chk($sformatf("t2_order%0d", k), acc_log[k], t2_exp[k]);
    run(30);

    // Packet lock: requester 2 keeps the grant for its three bytes.
    do_reset("rst3");
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    run_until(1, 50);
    push(0, 8'h10, 1'b1);
    push(3, 8'h30, 1'b1);
    run_until(5, 400);
    for (int k = 0; k < 5; k++) chk($sformatf("t3_order%0d", k), acc_log[k], t3_exp[k]);
    run(30);

    // External busy holds off a valid requester.
    do_reset("rst5");
    push(1, 8'h3C, 1'b1);
    u_len = 10;
    obs_rdy = 0;
    run(10);
    chk("t5_held_off", obs_rdy, 0);
    tick();
    chk("t5_taken", obs_rdy, 1);
    run(30);

    // Timeout: no BUSY after the strobe.
    do_reset("rst4");
    k_noresp = 100;
    push(3, 8'hC3, 1'b1);
    wr_cyc = -1; err_cyc = -1;
    run(40);
    chk("t4_latency", err_cyc - wr_cyc, 17);
    chk("t4_err_set", ERR_TIMEOUT, 1);
    chk("t4_idle", ACTIVE, 0);
    k_clr = 100;
    tick();
    k_clr = 0;
    tick();
    chk("t4_cleared", ERR_TIMEOUT, 0);
    k_clr_infl = 1'b1;
    push(3, 8'hC4, 1'b1);
    wr_cyc = -1; err_cyc = -1;
    run(40);
    chk("t4_set_wins", ERR_TIMEOUT, 1);
    chk("t4_latency2", err_cyc - wr_cyc, 17);
    k_clr_infl = 1'b0;
    k_noresp = 0;

    // Reset while a locked packet is in WAIT_DONE.
    do_reset("rst6a");
    k_lmin = 20; k_lmax = 20;
    for (int j = 0; j < 3; j++) push(1, N'($urandom), 1'b0);
    begin
      int b = 0;
      while (!(m_lock && m_infl && m_saw && acc_log.size() >= 2) && b < 200) begin
        tick();
        b++;
      end
      chk("t6_reach_wait_done", m_lock && m_infl && m_saw, 1);
    end
    do_reset("t6_rst");
    push(0, 8'h01, 1'b1);
    push(1, 8'h11, 1'b1);
    run_until(1, 50);
    chk("t6_first_grant", acc_log[0], 0);
    run(60);

    // Randomized traffic.
    do_reset("rst7");
    k_stall = 20; k_refill = 30; k_noresp = 5; k_ext = 5; k_clr = 3;
    k_dly = 2; k_lmin = 1; k_lmax = 6;
    run(3000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter byte interface (parallel data in, WR strobe, BUSY status) among NREQ requesters.
- Each requester presents bytes on a valid/ready handshake.
- The arbiter picks one requester round-robin and can hold the grant for a whole packet.
- It sequences the UART through issue, wait-start and wait-done phases, with a timeout if BUSY never asserts.
- Sits between firmware/host-side byte sources and the UART transmitter.

Parameters:
NREQ, 4, number of requesters (2..8)
N, 8, byte width; must match the UART data width
PACKET_LOCK, 1, 1 = hold grant until the byte with REQ_LAST=1 is accepted; 0 = re-arbitrate after every byte
TIMEOUT, 1024, cycles allowed in WAIT_BUSY for UART_BUSY to rise before abort (>=2)

Ports:
CLOCK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
REQ_VALID  input  NREQ  per-requester byte valid
REQ_DATA  input  NREQ*N  per-requester byte; requester i uses bits [i*N +: N]
REQ_LAST  input  NREQ  per-requester last-byte-of-packet flag
REQ_READY  output  NREQ  one-hot accept pulse; byte i is taken when REQ_VALID[i] & REQ_READY[i]
UART_DATAI  output  N  byte driven to the UART
UART_WR  output  1  one-cycle write strobe to the UART
UART_BUSY  input  1  UART transmitter busy
GRANT_ID  output  clog2(NREQ)  index of the last accepted requester
ACTIVE  output  1  high whenever the state is not ARB
ERR_TIMEOUT  output  1  sticky timeout flag
CLR_ERR  input  1  synchronous clear of ERR_TIMEOUT

Behaviour:
- Reset values (async, RESET_N=0):
  - state=ARB, UART_WR=0, UART_DATAI=0, GRANT_ID=0, ERR_TIMEOUT=0.
  - Round-robin pointer ptr=NREQ-1, so requester 0 has priority first.
  - lock=0, timeout counter=0.
  - REQ_READY=0 and ACTIVE=0.
- States: ARB -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> ARB.
- ARB:
  - Requester selection:
    - If lock=1: only requester GRANT_ID is eligible.
    - Otherwise: search ptr+1, ptr+2, ... modulo NREQ and take the first with REQ_VALID=1.
  - Acceptance condition: an eligible requester is found and UART_BUSY=0.
  - REQ_READY is combinational. It is high only for the selected index, only in ARB, and only when the acceptance condition holds.
  - On acceptance (clock edge):
    - UART_DATAI <= the selected byte; GRANT_ID <= selected index; state <= ISSUE.
    - If PACKET_LOCK=1: lock <= ~REQ_LAST[sel]. If PACKET_LOCK=0: lock stays 0.
    - ptr <= sel when the byte ends the grant (lock will be 0). Otherwise ptr is unchanged.
  - If UART_BUSY=1 (an external sender is active), no acceptance occurs and all REQ_READY stay 0.
  - If locked and the locked requester drops valid, the arbiter waits indefinitely; other requesters are not served.
- ISSUE: UART_WR=1 for exactly this one cycle; timeout counter <= 0; then state <= WAIT_BUSY.
- WAIT_BUSY:
  - UART_BUSY=1 -> WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 (TIMEOUT cycles spent in WAIT_BUSY):
    - ERR_TIMEOUT <= 1, lock <= 0, ptr <= GRANT_ID, state <= ARB.
    - The byte is dropped and not retried.
- WAIT_DONE: stay while UART_BUSY=1. UART_BUSY=0 -> ARB.
- UART_DATAI is held stable from acceptance until the next acceptance.
- Minimum byte-to-byte spacing is 4 cycles plus the UART frame time. At most one byte is outstanding.
- ERR_TIMEOUT:
  - Set has priority over CLR_ERR in the same cycle.
  - CLR_ERR has no other effect.
- ACTIVE = (state != ARB).
- RESET_N asserted mid-frame: all state returns to reset values immediately. UART_WR drops; the in-flight byte is abandoned.
- Throughput is one byte per UART frame. The arbiter adds no buffering.

Test Plan:
1. Single requester: REQ_VALID[0]=1, byte 0x5A, LAST=1; UART model raises BUSY 1 cycle after WR for 20 cycles.
   -> REQ_READY[0] pulses once; UART_WR is high for exactly 1 cycle, the cycle after acceptance; UART_DATAI=0x5A; GRANT_ID=0; ACTIVE falls once BUSY falls.
2. Round-robin, PACKET_LOCK=0: all four requesters valid continuously, LAST=1.
   -> Bytes are accepted in order 0,1,2,3,0,1; every REQ_READY is one-hot.
3. Packet lock, PACKET_LOCK=1: requester 2 sends 3 bytes (LAST on the third) while requesters 0 and 3 are valid.
   -> All three bytes come from 2; the next grant goes to 3, then 0.
4. Timeout, TIMEOUT=16: UART_BUSY held at 0 after WR.
   -> ERR_TIMEOUT rises exactly 16 cycles after entering WAIT_BUSY; the state returns to ARB; CLR_ERR pulse clears the flag; simultaneous set and clear leaves the flag at 1.
5. External busy: UART_BUSY=1 while REQ_VALID[1]=1.
   -> REQ_READY stays 0 until BUSY falls; the byte is then accepted on the next cycle.
6. Reset mid-packet: RESET_N pulsed low during WAIT_DONE of a locked packet.
   -> Outputs take reset values asynchronously; after release, requester 0 wins if valid and the lock is cleared.
